// File: rtl/mult5_fi.sv
// ---------------------------------------------------------------------------
// mult5_fi -- 5x5 unsigned array multiplier with per-net stuck-at injection
//
// Ports:
//   clk           in   1   rising-edge clock
//   rst           in   1   asynchronous, active-high reset (clears out)
//   A             in   5   multiplicand, unsigned
//   B             in   5   multiplier, unsigned
//   fault_places  in  51   bit i = 1 forces net i to fault_control[i]
//   fault_control in  51   stuck value for net i (0 = SA0, 1 = SA1)
//   out           out 10   registered product, latency 1
//
// Net map (51 injectable nets):
//   0-24  partial products pp[5*j+k] = B[j] & A[k]
//   25-34 pre-register product bits P0..P9
//   35-39 / 40-44 / 45-49  forwarded sum bits [5:1] of rows 1 / 2 / 3
//   50    carry-in of the row-4 adder (fault-free 0)
//
// Build option: define FAULT_INJ_EN to insert the fault muxes. Without it
// every net takes its fault-free value and the fault ports are ignored.
// ---------------------------------------------------------------------------
module mult5_fi #(
    parameter int NUM_FAULTS = 51
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4:0]            A,
    input  logic [4:0]            B,
    input  logic [NUM_FAULTS-1:0] fault_places,
    input  logic [NUM_FAULTS-1:0] fault_control,
    output logic [9:0]            out
);

    logic [NUM_FAULTS-1:0] fp;
    logic [NUM_FAULTS-1:0] fc;

`ifdef FAULT_INJ_EN
    assign fp = fault_places;
    assign fc = fault_control;
`else
    // Fault ports stay on the interface but feed nothing.
    logic unused_fault_ports;
    assign unused_fault_ports = ^{fault_places, fault_control};
    assign fp = '0;
    assign fc = '0;
`endif

    function automatic logic fmux(input logic place, input logic ctrl, input logic val);
        return place ? ctrl : val;
    endfunction

    logic [NUM_FAULTS-1:0] n;      // post-mux value of every net
    logic [4:0]            fwd;    // bits forwarded into the next row
    logic [5:0]            sum;
    logic                  cin;
    logic [9:0]            out_d;
    logic [9:0]            out_q;

    // Each net is muxed before anything downstream reads it, so a forced
    // value propagates through its fanout only.
    always_comb begin
        n   = '0;
        fwd = '0;
        sum = '0;
        cin = 1'b0;
        for (int j = 0; j < 5; j++)
            for (int k = 0; k < 5; k++)
                n[5*j+k] = fmux(fp[5*j+k], fc[5*j+k], B[j] & A[k]);

        // Row 0: P0 straight from pp[0], pp[4:1] forwarded zero-extended.
        n[25] = fmux(fp[25], fc[25], n[0]);
        fwd   = {1'b0, n[4:1]};

        for (int r = 1; r < 5; r++) begin
            cin = 1'b0;
            if (r == 4) begin
                n[50] = fmux(fp[50], fc[50], 1'b0);
                cin   = n[50];
            end
            sum = {1'b0, fwd} + {1'b0, n[5*r +: 5]} + {5'b0, cin};
            n[25+r] = fmux(fp[25+r], fc[25+r], sum[0]);
            if (r < 4) begin
                for (int b = 0; b < 5; b++)
                    n[30+5*r+b] = fmux(fp[30+5*r+b], fc[30+5*r+b], sum[b+1]);
                fwd = n[30+5*r +: 5];
            end else begin
                // Row 4 upper bits are P5..P9 directly.
                for (int b = 1; b < 6; b++)
                    n[29+b] = fmux(fp[29+b], fc[29+b], sum[b]);
            end
        end
        out_d = n[34:25];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) out_q <= '0;
        else     out_q <= out_d;
    end

    assign out = out_q;

endmodule

// File: tb/tb_mult5_fi.sv
module tb_mult5_fi;

`ifdef FAULT_INJ_EN
    localparam bit FI = 1'b1;
`else
    localparam bit FI = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  A = '0;
    logic [4:0]  B = '0;
    logic [50:0] fault_places  = '0;
    logic [50:0] fault_control = '0;
    logic [9:0]  out;

    int n_chk  = 0;
    int n_fail = 0;

    mult5_fi dut (
        .clk          (clk),
        .rst          (rst),
        .A            (A),
        .B            (B),
        .fault_places (fault_places),
        .fault_control(fault_control),
        .out          (out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one vector just after an edge, check one edge later.
    task automatic run(input string tag, input logic [4:0] a, input logic [4:0] b,
                       input logic [50:0] fpl, input logic [50:0] fct,
                       input logic [9:0] exp_fi, input logic [9:0] exp_ff);
        A = a; B = b; fault_places = fpl; fault_control = fct;
        @(posedge clk); #1;
        chk(tag, out, FI ? exp_fi : exp_ff);
    endtask

    localparam logic [50:0] ONE = 51'd1;

    initial begin
        // Reset behaviour
        A = 5'd31; B = 5'd31;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_reset", out, 10'd961);
        rst = 1'b1; #1;
        chk("reset_async", out, 10'd0);
        @(posedge clk); #1;
        chk("reset_held", out, 10'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("reset_release", out, 10'd961);

        // Mid-stream reset discards the in-flight product
        A = 5'd27; B = 5'd18; #2;
        rst = 1'b1; #1;
        chk("reset_midstream", out, 10'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("after_midstream", out, 10'd486);

        // Fault-free sweep
        run("ff_27x18", 5'd27, 5'd18, '0, '0, 10'd486, 10'd486);
        run("ff_29x24", 5'd29, 5'd24, '0, '0, 10'd696, 10'd696);
        run("ff_31x30", 5'd31, 5'd30, '0, '0, 10'd930, 10'd930);
        run("ff_0x0",   5'd0,  5'd0,  '0, '0, 10'd0,   10'd0);
        run("ff_1x31",  5'd1,  5'd31, '0, '0, 10'd31,  10'd31);
        run("ff_31x1",  5'd31, 5'd1,  '0, '0, 10'd31,  10'd31);

        // SA1 on net 5 (B[1]&A[0])
        run("sa1_n5_0x0",   5'd0,  5'd0,  ONE << 5, ONE << 5, 10'd2,   10'd0);
        run("sa1_n5_1x1",   5'd1,  5'd1,  ONE << 5, ONE << 5, 10'd3,   10'd1);
        run("sa1_n5_2x1",   5'd2,  5'd1,  ONE << 5, ONE << 5, 10'd4,   10'd2);
        run("sa1_n5_27x18", 5'd27, 5'd18, ONE << 5, ONE << 5, 10'd486, 10'd486);

        // SA0 on P0, SA1 on P9
        run("sa0_n25", 5'd3, 5'd17, ONE << 25, '0, 10'd50, 10'd51);
        run("sa1_n34", 5'd0, 5'd0, ONE << 34, ONE << 34, 10'd512, 10'd0);

        // SA1 on row-4 carry-in
        run("sa1_n50", 5'd0, 5'd0, ONE << 50, ONE << 50, 10'd16, 10'd0);

        // Forced value equal to fault-free value: no effect (pp0 = 1 for 3x5)
        run("force_same", 5'd3, 5'd5, ONE, ONE, 10'd15, 10'd15);
        // SA0 on pp0 for the same vector does change it when enabled
        run("sa0_n0", 5'd3, 5'd5, ONE, '0, 10'd14, 10'd15);

        // Fault vector change alone shows up after the next edge
        run("fault_clear", 5'd3, 5'd5, '0, '0, 10'd15, 10'd15);

        // Everything forced to 1
        run("all_sa1", 5'd21, 5'd13, '1, '1, 10'd1023, 10'd273);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Hard time bound so the run can never hang.
    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1);
    end

endmodule
